// File: rtl/recv_arp_pkt.sv
// recv_arp_pkt: receives a 32-bit word stream carrying an Ethernet/ARP frame,
// validates the fixed header words and presents the decoded ARP fields.
// Optional feature macro: ARP_TPA_FILTER_EN - when defined, a complete frame
// whose target protocol address differs from i_my_ip is dropped (o_err)
// instead of being presented (o_arp_vld).
module recv_arp_pkt #(
  parameter int MAX_WORDS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_eth_sop,
  input  logic        i_eth_eop,
  input  logic        i_eth_vld,
  input  logic [31:0] i_eth_data,
  output logic        o_eth_rdy,
  input  logic [31:0] i_my_ip,
  output logic        o_arp_vld,
  output logic [47:0] o_dst_mac,
  output logic [47:0] o_src_mac,
  output logic [15:0] o_arp_opcode,
  output logic [47:0] o_arp_sha,
  output logic [47:0] o_arp_tha,
  output logic [31:0] o_arp_spa,
  output logic [31:0] o_arp_tpa,
  output logic        o_err,
  output logic [15:0] o_drop_cnt
);

  // Counter wide enough for both the header index (0..10) and MAX_WORDS.
  localparam int TW = $clog2(MAX_WORDS + 1);
  localparam int CW = (TW > 4) ? TW : 4;
  localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_WORDS);
  localparam logic [CW-1:0] LAST_HDR = CW'(10);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_PAD  = 3'd2,
    S_DROP = 3'd3,
    S_DONE = 3'd4
  } state_e;

  typedef struct packed {
    logic [47:0] dst;
    logic [47:0] src;
    logic [15:0] opcode;
    logic [47:0] sha;
    logic [31:0] spa;
    logic [47:0] tha;
    logic [31:0] tpa;
  } arp_fields_t;

  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;      // number of words accepted in this frame
  arp_fields_t sh_q, sh_d;          // shadow copy built while the frame arrives
  arp_fields_t out_q;               // presented fields, updated only on o_arp_vld
  logic        rdy_q;
  logic        vld_q, vld_d;
  logic        err_q, err_d;
  logic [15:0] drop_q;
  logic        acc_s;
  logic        bad_s;
  logic        finish_s;            // frame completes on this word

`ifndef ARP_TPA_FILTER_EN
  logic unused_my_ip_s;
  assign unused_my_ip_s = ^i_my_ip;
`endif

  // Next-state, field capture and pulse generation for each accepted word.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sh_d     = sh_q;
    err_d    = 1'b0;
    vld_d    = 1'b0;
    bad_s    = 1'b0;
    finish_s = 1'b0;
    acc_s    = i_eth_vld & rdy_q;

    if (state_q == S_DONE) begin
      state_d = S_IDLE;
    end else if (acc_s && i_eth_sop) begin
      // A start word is always w0; outside S_IDLE it aborts the current frame.
      if (state_q != S_IDLE) begin
        err_d = 1'b1;
      end else begin
        err_d = 1'b0;
      end
      sh_d.dst[47:32] = i_eth_data[15:0];
      cnt_d = CW'(1);
      if (i_eth_eop) begin
        err_d   = 1'b1;
        state_d = S_IDLE;
      end else if (i_eth_data[31:16] != 16'h0000) begin
        state_d = S_DROP;
      end else begin
        state_d = S_HDR;
      end
    end else if (acc_s) begin
      case (state_q)
        S_HDR: begin
          cnt_d = cnt_q + CW'(1);
          case (cnt_q)
            CW'(1): sh_d.dst[31:0] = i_eth_data;
            CW'(2): sh_d.src[47:16] = i_eth_data;
            CW'(3): begin
              sh_d.src[15:0] = i_eth_data[31:16];
              bad_s = (i_eth_data[15:0] != 16'h0806);
            end
            CW'(4): bad_s = (i_eth_data != 32'h0001_0800);
            CW'(5): begin
              bad_s = (i_eth_data[31:16] != 16'h0604);
              sh_d.opcode = i_eth_data[15:0];
            end
            CW'(6): sh_d.sha[47:16] = i_eth_data;
            CW'(7): begin
              sh_d.sha[15:0]  = i_eth_data[31:16];
              sh_d.spa[31:16] = i_eth_data[15:0];
            end
            CW'(8): begin
              sh_d.spa[15:0]  = i_eth_data[31:16];
              sh_d.tha[47:32] = i_eth_data[15:0];
            end
            CW'(9):  sh_d.tha[31:0] = i_eth_data;
            CW'(10): sh_d.tpa = i_eth_data;
            default: bad_s = 1'b1;
          endcase
          if (cnt_q == LAST_HDR) begin
            if (i_eth_eop) begin
              finish_s = 1'b1;
            end else if (cnt_d == MAX_CNT) begin
              state_d = S_DROP;
            end else begin
              state_d = S_PAD;
            end
          end else if (i_eth_eop) begin
            // Runt: frame ended before the target protocol address.
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else if (bad_s || (cnt_d == MAX_CNT)) begin
            state_d = S_DROP;
          end else begin
            state_d = S_HDR;
          end
        end
        S_PAD: begin
          cnt_d = cnt_q + CW'(1);
          if (i_eth_eop) begin
            finish_s = 1'b1;
          end else if (cnt_d == MAX_CNT) begin
            state_d = S_DROP;
          end else begin
            state_d = S_PAD;
          end
        end
        S_DROP: begin
          if (i_eth_eop) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_DROP;
          end
        end
        default: begin
          // S_IDLE: stray words without a start marker are ignored.
          state_d = state_q;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    // A finished frame is presented one cycle after its eop word.
    if (finish_s) begin
      state_d = S_DONE;
`ifdef ARP_TPA_FILTER_EN
      if (sh_d.tpa != i_my_ip) begin
        err_d = 1'b1;
      end else begin
        vld_d = 1'b1;
      end
`else
      vld_d = 1'b1;
`endif
    end else begin
      vld_d = 1'b0;
    end
  end

  // FSM state, word counter, shadow fields and handshake/pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      rdy_q   <= 1'b1;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      rdy_q   <= (state_d != S_DONE);
      vld_q   <= vld_d;
      err_q   <= err_d;
    end
  end

  // Presented fields and the saturating drop counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q  <= '0;
      drop_q <= 16'h0000;
    end else begin
      if (vld_d) begin
        out_q <= sh_d;
      end
      if (err_d && (drop_q != 16'hFFFF)) begin
        drop_q <= drop_q + 16'd1;
      end
    end
  end

  assign o_eth_rdy    = rdy_q;
  assign o_arp_vld    = vld_q;
  assign o_err        = err_q;
  assign o_drop_cnt   = drop_q;
  assign o_dst_mac    = out_q.dst;
  assign o_src_mac    = out_q.src;
  assign o_arp_opcode = out_q.opcode;
  assign o_arp_sha    = out_q.sha;
  assign o_arp_spa    = out_q.spa;
  assign o_arp_tha    = out_q.tha;
  assign o_arp_tpa    = out_q.tpa;

endmodule

// File: tb/tb_recv_arp_pkt.sv
// Self-checking bench for recv_arp_pkt: directed scenarios followed by random
// frames, each judged by a frame-level reference model.
module tb_recv_arp_pkt;
  localparam int MAX_WORDS = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_eth_sop, i_eth_eop, i_eth_vld;
  logic [31:0] i_eth_data, i_my_ip;
  logic        o_eth_rdy, o_arp_vld, o_err;
  logic [47:0] o_dst_mac, o_src_mac, o_arp_sha, o_arp_tha;
  logic [15:0] o_arp_opcode, o_drop_cnt;
  logic [31:0] o_arp_spa, o_arp_tpa;

  always #5 clk = ~clk;

  recv_arp_pkt #(.MAX_WORDS(MAX_WORDS)) dut (
    .clk(clk), .rst(rst),
    .i_eth_sop(i_eth_sop), .i_eth_eop(i_eth_eop), .i_eth_vld(i_eth_vld),
    .i_eth_data(i_eth_data), .o_eth_rdy(o_eth_rdy), .i_my_ip(i_my_ip),
    .o_arp_vld(o_arp_vld), .o_dst_mac(o_dst_mac), .o_src_mac(o_src_mac),
    .o_arp_opcode(o_arp_opcode), .o_arp_sha(o_arp_sha), .o_arp_tha(o_arp_tha),
    .o_arp_spa(o_arp_spa), .o_arp_tpa(o_arp_tpa), .o_err(o_err),
    .o_drop_cnt(o_drop_cnt)
  );

  typedef struct packed {
    logic [47:0] dst;
    logic [47:0] src;
    logic [15:0] opcode;
    logic [47:0] sha;
    logic [31:0] spa;
    logic [47:0] tha;
    logic [31:0] tpa;
  } fld_t;
  typedef logic [31:0] wq_t[$];

  int   checks = 0;
  int   errors = 0;
  int   n_err = 0;
  int   n_vld = 0;
  fld_t exp_out;
  int   exp_drop;

  // Count output pulses independently of the per-frame checks.
  always @(negedge clk) begin
    if (!rst) begin
      if (o_err) n_err++;
      if (o_arp_vld) n_vld++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not complete, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [271:0] obs, input logic [271:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [271:0] dut_fields();
    return {o_dst_mac, o_src_mac, o_arp_opcode, o_arp_sha, o_arp_spa, o_arp_tha, o_arp_tpa};
  endfunction

  function automatic wq_t build(input fld_t f, input int pad, input bit rnd_pad);
    wq_t w;
    w.push_back({16'h0000, f.dst[47:32]});
    w.push_back(f.dst[31:0]);
    w.push_back(f.src[47:16]);
    w.push_back({f.src[15:0], 16'h0806});
    w.push_back(32'h0001_0800);
    w.push_back({8'h06, 8'h04, f.opcode});
    w.push_back(f.sha[47:16]);
    w.push_back({f.sha[15:0], f.spa[31:16]});
    w.push_back({f.spa[15:0], f.tha[47:32]});
    w.push_back(f.tha[31:0]);
    w.push_back(f.tpa);
    for (int i = 0; i < pad; i++) w.push_back(rnd_pad ? $urandom() : 32'h0);
    return w;
  endfunction

  // Reference: a frame is complete if it has 11..MAX_WORDS words and the
  // fixed header words hold their required values.
  function automatic bit reaches_done(input wq_t w);
    logic [31:0] a0, a3, a4, a5;
    if (w.size() < 11 || w.size() > MAX_WORDS) return 1'b0;
    a0 = w[0]; a3 = w[3]; a4 = w[4]; a5 = w[5];
    return (a0[31:16] == 16'h0000) && (a3[15:0] == 16'h0806) &&
           (a4 == 32'h0001_0800) && (a5[31:16] == 16'h0604);
  endfunction

  function automatic fld_t decode(input wq_t w);
    fld_t f;
    logic [31:0] a[11];
    for (int i = 0; i < 11; i++) a[i] = w[i];
    f.dst    = {a[0][15:0], a[1]};
    f.src    = {a[2], a[3][31:16]};
    f.opcode = a[5][15:0];
    f.sha    = {a[6], a[7][31:16]};
    f.spa    = {a[7][15:0], a[8][31:16]};
    f.tha    = {a[8][15:0], a[9]};
    f.tpa    = a[10];
    return f;
  endfunction

  function automatic bit filter_ok(input wq_t w);
`ifdef ARP_TPA_FILTER_EN
    return w[10] == i_my_ip;
`else
    return 1'b1;
`endif
  endfunction

  function automatic fld_t rand_fields();
    fld_t f;
    f.dst    = 48'({$urandom(), $urandom()});
    f.src    = 48'({$urandom(), $urandom()});
    f.opcode = 16'($urandom());
    f.sha    = 48'({$urandom(), $urandom()});
    f.spa    = $urandom();
    f.tha    = 48'({$urandom(), $urandom()});
    f.tpa    = $urandom();
    return f;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one word until accepted, after 0..2 idle cycles carrying junk.
  task automatic send_beat(input logic [31:0] d, input bit sop, input bit eop);
    int gaps = $urandom_range(0, 2);
    bit took = 1'b0;
    for (int g = 0; g < gaps; g++) begin
      i_eth_vld  = 1'b0;
      i_eth_sop  = 1'($urandom_range(0, 1));
      i_eth_eop  = 1'($urandom_range(0, 1));
      i_eth_data = $urandom();
      step();
    end
    i_eth_vld = 1'b1; i_eth_sop = sop; i_eth_eop = eop; i_eth_data = d;
    for (int t = 0; t < 8 && !took; t++) begin
      took = o_eth_rdy;
      step();
    end
    i_eth_vld = 1'b0; i_eth_sop = 1'b0; i_eth_eop = 1'b0;
    chk("accept", took, 1'b1);
  endtask

  // Check the cycle right after the eop word and the cycle after that.
  task automatic check_after(input string tag, input bit good, input bit reach,
                             input int e0, input int v0);
    chk({tag, "_vld"}, o_arp_vld, good);
    chk({tag, "_err"}, o_err, !good);
    chk({tag, "_rdy"}, o_eth_rdy, !reach);
    chk({tag, "_fields"}, dut_fields(), exp_out);
    chk({tag, "_drop"}, o_drop_cnt, exp_drop);
    step();
    chk({tag, "_vld_end"}, o_arp_vld, 1'b0);
    chk({tag, "_err_end"}, o_err, 1'b0);
    chk({tag, "_rdy_end"}, o_eth_rdy, 1'b1);
    chk({tag, "_hold"}, dut_fields(), exp_out);
    chk({tag, "_nerr"}, n_err - e0, !good);
    chk({tag, "_nvld"}, n_vld - v0, good);
  endtask

  task automatic run_frame(input string tag, input wq_t w);
    int e0 = n_err;
    int v0 = n_vld;
    bit reach, good;
    for (int i = 0; i < w.size(); i++) send_beat(w[i], i == 0, i == w.size() - 1);
    reach = reaches_done(w);
    good  = reach && filter_ok(w);
    if (good) exp_out = decode(w);
    else exp_drop = (exp_drop == 65535) ? 65535 : exp_drop + 1;
    check_after(tag, good, reach, e0, v0);
  endtask

  initial begin
    fld_t f32, fa, fb, fr;
    wq_t  w, wa, wb;
    logic [31:0] tmp;
    int   e0, v0, kind, sel;

    rst = 1'b1; i_eth_vld = 1'b0; i_eth_sop = 1'b0; i_eth_eop = 1'b0;
    i_eth_data = 32'h0; i_my_ip = 32'hC0A8_000A;
    exp_out = '0; exp_drop = 0;
    step(); step();
    chk("rst_vld", o_arp_vld, 1'b0);
    chk("rst_err", o_err, 1'b0);
    chk("rst_rdy", o_eth_rdy, 1'b1);
    chk("rst_drop", o_drop_cnt, 16'd0);
    chk("rst_fields", dut_fields(), 272'd0);
    rst = 1'b0;
    step();

    // Good ARP request.
    f32.dst = 48'hFFFF_FFFF_FFFF; f32.src = 48'h0011_2233_4455; f32.opcode = 16'h0001;
    f32.sha = 48'h0011_2233_4455; f32.spa = 32'hC0A8_0001; f32.tha = 48'h0;
    f32.tpa = 32'hC0A8_000A;
    run_frame("good", build(f32, 0, 1'b0));
    chk("good_opcode", o_arp_opcode, 16'h0001);

    // Padding up to exactly MAX_WORDS words.
    run_frame("pad5", build(f32, 5, 1'b0));

    // Wrong ethertype.
    w = build(rand_fields(), 0, 1'b0);
    tmp = w[3]; tmp[15:0] = 16'h0800; w[3] = tmp;
    run_frame("badtype", w);
    chk("badtype_cnt", o_drop_cnt, 16'd1);

    // Runt with eop on w6, then a good frame.
    wa = build(rand_fields(), 0, 1'b0);
    w.delete();
    for (int i = 0; i < 7; i++) w.push_back(wa[i]);
    run_frame("runt", w);
    run_frame("after_runt", build(f32, 0, 1'b0));

    // Oversize: one word beyond MAX_WORDS.
    run_frame("oversize", build(f32, MAX_WORDS - 10, 1'b1));

    // Target address filter (drops only when the filter is built in).
    i_my_ip = 32'hC0A8_0002;
    run_frame("filter", build(f32, 0, 1'b0));
    i_my_ip = 32'hC0A8_000A;

    // Mid-frame restart at w5.
    fa = rand_fields(); fb = rand_fields(); fb.tpa = i_my_ip;
    wa = build(fa, 0, 1'b0); wb = build(fb, 0, 1'b0);
    e0 = n_err; v0 = n_vld;
    for (int i = 0; i < 5; i++) send_beat(wa[i], i == 0, 1'b0);
    send_beat(wb[0], 1'b1, 1'b0);
    exp_drop = exp_drop + 1;
    chk("restart_err", o_err, 1'b1);
    chk("restart_drop", o_drop_cnt, exp_drop);
    for (int i = 1; i < 11; i++) send_beat(wb[i], 1'b0, i == 10);
    exp_out = decode(wb);
    check_after("restart_frame", 1'b1, 1'b1, e0 + 1, v0);

    // Reset in the middle of a frame: no error pulse, everything cleared.
    e0 = n_err;
    for (int i = 0; i < 4; i++) send_beat(wa[i], i == 0, 1'b0);
    #2 rst = 1'b1;
    #1;
    exp_out = '0; exp_drop = 0;
    chk("midrst_err", o_err, 1'b0);
    chk("midrst_drop", o_drop_cnt, 16'd0);
    chk("midrst_fields", dut_fields(), 272'd0);
    chk("midrst_rdy", o_eth_rdy, 1'b1);
    step();
    rst = 1'b0;
    step();
    chk("midrst_nerr", n_err - e0, 0);
    run_frame("after_rst", build(f32, 0, 1'b0));

    // Random frames of every kind.
    for (int n = 0; n < 40; n++) begin
      fr = rand_fields();
      i_my_ip = ($urandom_range(0, 3) != 0) ? fr.tpa : $urandom();
      kind = $urandom_range(0, 4);
      case (kind)
        0: w = build(fr, 0, 1'b1);
        1: w = build(fr, $urandom_range(1, MAX_WORDS - 11), 1'b1);
        2: begin
          w = build(fr, $urandom_range(0, 2), 1'b1);
          sel = $urandom_range(0, 3);
          case (sel)
            0: begin tmp = w[0]; tmp[31:16] ^= 16'($urandom_range(1, 65535)); w[0] = tmp; end
            1: begin tmp = w[3]; tmp[15:0] ^= 16'($urandom_range(1, 65535)); w[3] = tmp; end
            2: begin tmp = w[4]; tmp ^= {$urandom_range(0, 65535), 16'h0001} ; w[4] = tmp; end
            default: begin tmp = w[5]; tmp[31:16] ^= 16'($urandom_range(1, 65535)); w[5] = tmp; end
          endcase
        end
        3: begin
          wa = build(fr, 0, 1'b0);
          w.delete();
          sel = $urandom_range(1, 10);
          for (int i = 0; i < sel; i++) w.push_back(wa[i]);
        end
        default: w = build(fr, MAX_WORDS - 11 + $urandom_range(1, 3), 1'b1);
      endcase
      run_frame("rand", w);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
